// File: rtl/alu_ctrl_md_pkg.sv
// ============================================================================
// alu_ctrl_pkg : opcode/funct encodings, ALU control codes, mul/div FSM states
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

package alu_ctrl_pkg;

   localparam logic [5:0] c_OP_RTYPE = 6'b000000;
   localparam logic [5:0] c_OP_ADDI  = 6'b001000;
   localparam logic [5:0] c_OP_LW    = 6'b100011;
   localparam logic [5:0] c_OP_SW    = 6'b101011;
   localparam logic [5:0] c_OP_JAL   = 6'b000011;
   localparam logic [5:0] c_OP_BEQ   = 6'b000100;
   localparam logic [5:0] c_OP_BNE   = 6'b000101;

   localparam logic [5:0] c_FN_SLL   = 6'b000000;
   localparam logic [5:0] c_FN_SRL   = 6'b000010;
   localparam logic [5:0] c_FN_JR    = 6'b001000;
   localparam logic [5:0] c_FN_MFHI  = 6'b010000;
   localparam logic [5:0] c_FN_MFLO  = 6'b010010;
   localparam logic [5:0] c_FN_MULT  = 6'b011000;
   localparam logic [5:0] c_FN_MULTU = 6'b011001;
   localparam logic [5:0] c_FN_DIV   = 6'b011010;
   localparam logic [5:0] c_FN_DIVU  = 6'b011011;
   localparam logic [5:0] c_FN_ADD   = 6'b100000;
   localparam logic [5:0] c_FN_SUB   = 6'b100010;
   localparam logic [5:0] c_FN_AND   = 6'b100100;
   localparam logic [5:0] c_FN_OR    = 6'b100101;
   localparam logic [5:0] c_FN_NOR   = 6'b100111;
   localparam logic [5:0] c_FN_SLT   = 6'b101010;

   localparam logic [3:0] c_ALU_JR      = 4'b0000;
   localparam logic [3:0] c_ALU_OR      = 4'b0001;
   localparam logic [3:0] c_ALU_ADD     = 4'b0010;
   localparam logic [3:0] c_ALU_DIV     = 4'b0011;
   localparam logic [3:0] c_ALU_BNE     = 4'b0100;
   localparam logic [3:0] c_ALU_SLL     = 4'b0101;
   localparam logic [3:0] c_ALU_SUB     = 4'b0110;
   localparam logic [3:0] c_ALU_SLT     = 4'b0111;
   localparam logic [3:0] c_ALU_SRL     = 4'b1000;
   localparam logic [3:0] c_ALU_NOR     = 4'b1001;
   localparam logic [3:0] c_ALU_MEM     = 4'b1010;
   localparam logic [3:0] c_ALU_AND     = 4'b1011;
   localparam logic [3:0] c_ALU_BEQ     = 4'b1100;
   localparam logic [3:0] c_ALU_HILO    = 4'b1101;
   localparam logic [3:0] c_ALU_JAL     = 4'b1110;
   localparam logic [3:0] c_ALU_MULT    = 4'b1111;
   localparam logic [3:0] c_ALU_ILLEGAL = 4'b1111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } md_state_t;

endpackage

`default_nettype wire

// File: rtl/alu_ctrl_md_muldiv_iter.sv
// ============================================================================
// muldiv_iter : iterative shift-add multiplier / restoring divider owning HI/LO
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module muldiv_iter
   import alu_ctrl_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter bit EN_DIV = 1'b1
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic             i_is_div,
   input  logic             i_signed,
   input  logic [WIDTH-1:0] i_rs,
   input  logic [WIDTH-1:0] i_rt,
   output logic             o_busy,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo,
   output logic             o_done,
   output logic             o_dbz
);

   localparam int                c_CW   = $clog2(WIDTH + 1);
   localparam logic [c_CW-1:0]   c_LAST = c_CW'(WIDTH - 1);

   md_state_t        r_state;
   logic [c_CW-1:0]  r_cnt;
   logic [WIDTH-1:0] r_opnd;
   logic [WIDTH-1:0] r_p_hi;
   logic [WIDTH-1:0] r_p_lo;
   logic             r_is_div;
   logic             r_neg_res;
   logic             r_neg_rem;
   logic             r_dbz;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic             r_done;
   logic             r_dbz_out;

   logic             w_rs_neg;
   logic             w_rt_neg;
   logic [WIDTH-1:0] w_rs_mag;
   logic [WIDTH-1:0] w_rt_mag;
   logic [WIDTH:0]   w_mul_sum;
   logic [WIDTH-1:0] w_mul_hi;
   logic [WIDTH-1:0] w_mul_lo;
   logic [WIDTH-1:0] w_div_hi;
   logic [WIDTH-1:0] w_div_lo;
   logic [2*WIDTH-1:0] w_prod_fix;
   logic [WIDTH-1:0] w_q_fix;
   logic [WIDTH-1:0] w_r_fix;

   assign w_rs_neg = i_signed & i_rs[WIDTH-1];
   assign w_rt_neg = i_signed & i_rt[WIDTH-1];
   assign w_rs_mag = w_rs_neg ? -i_rs : i_rs;
   assign w_rt_mag = w_rt_neg ? -i_rt : i_rt;

   // Multiplier bits shift out of r_p_lo while product bits shift in from the top.
   assign w_mul_sum = {1'b0, r_p_hi} + (r_p_lo[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
   assign w_mul_hi  = w_mul_sum[WIDTH:1];
   assign w_mul_lo  = {w_mul_sum[0], r_p_lo[WIDTH-1:1]};

   generate
      if (EN_DIV) begin : g_div
         logic [WIDTH:0] w_shift;
         logic [WIDTH:0] w_trial;
         assign w_shift  = {r_p_hi, r_p_lo[WIDTH-1]};
         assign w_trial  = w_shift - {1'b0, r_opnd};
         assign w_div_hi = w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
         assign w_div_lo = {r_p_lo[WIDTH-2:0], ~w_trial[WIDTH]};
      end else begin : g_no_div
         assign w_div_hi = '0;
         assign w_div_lo = '0;
      end
   endgenerate

   // A zero divisor leaves the dividend magnitude as remainder; only LO needs forcing.
   assign w_prod_fix = r_neg_res ? -{r_p_hi, r_p_lo} : {r_p_hi, r_p_lo};
   assign w_q_fix    = r_dbz ? '1 : (r_neg_res ? -r_p_lo : r_p_lo);
   assign w_r_fix    = r_neg_rem ? -r_p_hi : r_p_hi;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_opnd    <= '0;
         r_p_hi    <= '0;
         r_p_lo    <= '0;
         r_is_div  <= 1'b0;
         r_neg_res <= 1'b0;
         r_neg_rem <= 1'b0;
         r_dbz     <= 1'b0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_done    <= 1'b0;
         r_dbz_out <= 1'b0;
      end else begin
         r_done    <= 1'b0;
         r_dbz_out <= 1'b0;
         case (r_state)
            IDLE: begin
               if (i_start) begin
                  r_is_div  <= i_is_div;
                  r_neg_res <= w_rs_neg ^ w_rt_neg;
                  r_neg_rem <= w_rs_neg;
                  r_dbz     <= i_is_div & (i_rt == '0);
                  r_cnt     <= '0;
                  r_p_hi    <= '0;
                  r_opnd    <= i_is_div ? w_rt_mag : w_rs_mag;
                  r_p_lo    <= i_is_div ? w_rs_mag : w_rt_mag;
                  r_state   <= CALC;
               end
            end
            CALC: begin
               r_p_hi <= r_is_div ? w_div_hi : w_mul_hi;
               r_p_lo <= r_is_div ? w_div_lo : w_mul_lo;
               r_cnt  <= r_cnt + 1'b1;
               if (r_cnt == c_LAST) begin
                  r_state <= FIX;
               end
            end
            FIX: begin
               if (r_is_div) begin
                  r_hi      <= w_r_fix;
                  r_lo      <= w_q_fix;
                  r_dbz_out <= r_dbz;
               end else begin
                  r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                  r_lo <= w_prod_fix[WIDTH-1:0];
               end
               r_done  <= 1'b1;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_busy = (r_state != IDLE);
   assign o_hi   = r_hi;
   assign o_lo   = r_lo;
   assign o_done = r_done;
   assign o_dbz  = r_dbz_out;

endmodule

`default_nettype wire

// File: rtl/alu_ctrl_md.sv
// ============================================================================
// alu_ctrl_md : MIPS ALU control decode, illegal detect, HI/LO interlock
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module alu_ctrl_md
   import alu_ctrl_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter bit EN_DIV = 1'b1
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_in_valid,
   input  logic [5:0]       i_opcode,
   input  logic [5:0]       i_funct,
   input  logic [WIDTH-1:0] i_rs_val,
   input  logic [WIDTH-1:0] i_rt_val,
   output logic [3:0]       o_alu_ctrl,
   output logic             o_illegal,
   output logic             o_hilo_sel,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo,
   output logic             o_md_done,
   output logic             o_div_by_zero,
   output logic             o_stall
);

   logic [3:0] w_alu_ctrl;
   logic       w_illegal;
   logic       w_hilo_sel;
   logic       w_md_class;
   logic       w_is_div;
   logic       w_signed;
   logic       w_mfhilo;
   logic       w_busy;

   always_comb begin
      w_alu_ctrl = c_ALU_ILLEGAL;
      w_illegal  = 1'b0;
      w_hilo_sel = 1'b0;
      w_md_class = 1'b0;
      w_is_div   = 1'b0;
      w_signed   = 1'b0;
      w_mfhilo   = 1'b0;
      case (i_opcode)
         c_OP_RTYPE: begin
            case (i_funct)
               c_FN_ADD: w_alu_ctrl = c_ALU_ADD;
               c_FN_SUB: w_alu_ctrl = c_ALU_SUB;
               c_FN_AND: w_alu_ctrl = c_ALU_AND;
               c_FN_OR:  w_alu_ctrl = c_ALU_OR;
               c_FN_NOR: w_alu_ctrl = c_ALU_NOR;
               c_FN_SLT: w_alu_ctrl = c_ALU_SLT;
               c_FN_SLL: w_alu_ctrl = c_ALU_SLL;
               c_FN_SRL: w_alu_ctrl = c_ALU_SRL;
               c_FN_JR:  w_alu_ctrl = c_ALU_JR;
               c_FN_MULT, c_FN_MULTU: begin
                  w_alu_ctrl = c_ALU_MULT;
                  w_md_class = 1'b1;
                  w_signed   = (i_funct == c_FN_MULT);
               end
               c_FN_DIV, c_FN_DIVU: begin
                  if (EN_DIV) begin
                     w_alu_ctrl = c_ALU_DIV;
                     w_md_class = 1'b1;
                     w_is_div   = 1'b1;
                     w_signed   = (i_funct == c_FN_DIV);
                  end else begin
                     w_illegal = 1'b1;
                  end
               end
               c_FN_MFHI: begin
                  w_alu_ctrl = c_ALU_HILO;
                  w_hilo_sel = 1'b1;
                  w_mfhilo   = 1'b1;
               end
               c_FN_MFLO: begin
                  w_alu_ctrl = c_ALU_HILO;
                  w_mfhilo   = 1'b1;
               end
               default: w_illegal = 1'b1;
            endcase
         end
         c_OP_ADDI:         w_alu_ctrl = c_ALU_ADD;
         c_OP_LW, c_OP_SW:  w_alu_ctrl = c_ALU_MEM;
         c_OP_JAL:          w_alu_ctrl = c_ALU_JAL;
         c_OP_BEQ:          w_alu_ctrl = c_ALU_BEQ;
         c_OP_BNE:          w_alu_ctrl = c_ALU_BNE;
         default:           w_illegal  = 1'b1;
      endcase
   end

   // Only instructions touching the engine or HI/LO wait for it.
   assign o_stall = w_busy & i_in_valid & (w_md_class | w_mfhilo);

   muldiv_iter #(
      .WIDTH  (WIDTH),
      .EN_DIV (EN_DIV)
   ) u_muldiv (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_start  (i_in_valid & w_md_class & ~w_busy),
      .i_is_div (w_is_div),
      .i_signed (w_signed),
      .i_rs     (i_rs_val),
      .i_rt     (i_rt_val),
      .o_busy   (w_busy),
      .o_hi     (o_hi),
      .o_lo     (o_lo),
      .o_done   (o_md_done),
      .o_dbz    (o_div_by_zero)
   );

   assign o_alu_ctrl = w_alu_ctrl;
   assign o_illegal  = w_illegal;
   assign o_hilo_sel = w_hilo_sel;

endmodule

`default_nettype wire
